// File: rtl/iir_pkg.sv
// Shared constants and types for the iir biquad coefficient scheduler.
package iir_pkg;

    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A1 = 3'd3;
    localparam logic [2:0] COEF_A2 = 3'd4;

    localparam int DEF_B0 = 32'sd4096;
    localparam int DEF_B1 = 32'sd8192;
    localparam int DEF_B2 = 32'sd4096;
    localparam int DEF_A1 = 32'sd8192;
    localparam int DEF_A2 = 32'sd4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    // Reset value of one coefficient slot, matching the filter's own reset values.
    function automatic int coef_default(input logic [2:0] sel);
        int val;
        case (sel)
            COEF_B0: val = DEF_B0;
            COEF_B1: val = DEF_B1;
            COEF_B2: val = DEF_B2;
            COEF_A1: val = DEF_A1;
            COEF_A2: val = DEF_A2;
            default: val = 32'sd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Profile register file: one host write port, one asynchronous read port.
module iir_coef_bank
    import iir_pkg::*;
#(
    parameter int NUM_SECTIONS = 2,
    parameter int COEF_WIDTH   = 16,
    parameter int NUM_PROFILES = 4,
    localparam int SW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1,
    localparam int PW = $clog2(NUM_PROFILES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [PW-1:0]         wr_profile,
    input  logic [SW-1:0]         wr_section,
    input  logic [2:0]            wr_sel,
    input  logic [COEF_WIDTH-1:0] wr_value,
    input  logic [PW-1:0]         rd_profile,
    input  logic [SW-1:0]         rd_section,
    input  logic [2:0]            rd_sel,
    output logic [COEF_WIDTH-1:0] rd_value
);

    localparam logic [31:0] NP = NUM_PROFILES;
    localparam logic [31:0] NS = NUM_SECTIONS;

    logic [COEF_WIDTH-1:0] r_bank [NUM_PROFILES][NUM_SECTIONS][5];
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    assign w_wr_ok = wr_en && (32'(wr_profile) < NP) && (32'(wr_section) < NS) && (wr_sel <= COEF_A2);
    assign w_rd_ok = (32'(rd_profile) < NP) && (32'(rd_section) < NS) && (rd_sel <= COEF_A2);

    // Storage: defaults on reset, otherwise accept in-range host writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PROFILES; p++) begin
                for (int s = 0; s < NUM_SECTIONS; s++) begin
                    for (int c = 0; c < 5; c++) begin
                        r_bank[p][s][c] <= COEF_WIDTH'(coef_default(3'(c)));
                    end
                end
            end
        end else if (w_wr_ok) begin
            r_bank[wr_profile][wr_section][wr_sel] <= wr_value;
        end
    end

    // Asynchronous read; out-of-range indices read as zero.
    always_comb begin
        rd_value = '0;
        if (w_rd_ok) begin
            rd_value = r_bank[rd_profile][rd_section][rd_sel];
        end else begin
            rd_value = '0;
        end
    end

endmodule

// File: rtl/iir_coef_sched.sv
// Stalls the sample stream and streams a stored coefficient profile into the iir filter.
module iir_coef_sched
    import iir_pkg::*;
#(
    parameter int NUM_SECTIONS = 2,
    parameter int COEF_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_PROFILES = 4,
    localparam int SW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1,
    localparam int PW = $clog2(NUM_PROFILES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr_en,
    input  logic [PW-1:0]         cfg_profile,
    input  logic [SW-1:0]         cfg_section,
    input  logic [2:0]            cfg_sel,
    input  logic [COEF_WIDTH-1:0] cfg_value,
    input  logic                  switch_req,
    input  logic [PW-1:0]         switch_profile,
    output logic                  switch_ack,
    output logic                  switch_err,
    output logic                  busy,
    output logic [PW-1:0]         active_profile,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] iir_din,
    output logic                  iir_din_valid,
    output logic                  iir_coeff_wr_en,
    output logic [SW-1:0]         iir_section_index,
    output logic [2:0]            iir_coeff_sel,
    output logic [COEF_WIDTH-1:0] iir_coeff_value
);

    localparam logic [31:0] NP = NUM_PROFILES;
    localparam logic [31:0] NS = NUM_SECTIONS;

    sched_state_t          r_state;
    sched_state_t          w_next;
    logic [SW-1:0]         r_sec;
    logic [2:0]            r_sel;
    logic [PW-1:0]         r_target;
    logic [PW-1:0]         r_active;
    logic                  r_err;
    logic                  w_req_ok;
    logic                  w_last;
    logic [COEF_WIDTH-1:0] w_rd_value;

    iir_coef_bank #(
        .NUM_SECTIONS (NUM_SECTIONS),
        .COEF_WIDTH   (COEF_WIDTH),
        .NUM_PROFILES (NUM_PROFILES)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (cfg_wr_en),
        .wr_profile (cfg_profile),
        .wr_section (cfg_section),
        .wr_sel     (cfg_sel),
        .wr_value   (cfg_value),
        .rd_profile (r_target),
        .rd_section (r_sec),
        .rd_sel     (r_sel),
        .rd_value   (w_rd_value)
    );

    assign w_req_ok = (32'(switch_profile) < NP);
    assign w_last   = (r_sel == COEF_A2) && (32'(r_sec) == (NS - 32'd1));

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (switch_req && w_req_ok) begin
                    w_next = GATE;
                end else begin
                    w_next = IDLE;
                end
            end
            GATE: w_next = LOAD;
            LOAD: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = LOAD;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, write pointers, target/active profile and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sec    <= '0;
            r_sel    <= 3'd0;
            r_target <= '0;
            r_active <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == IDLE) && switch_req && !w_req_ok;
            // Latch the profile together with the accepted request.
            if ((r_state == IDLE) && switch_req && w_req_ok) begin
                r_target <= switch_profile;
            end
            if (r_state == GATE) begin
                r_sec <= '0;
                r_sel <= COEF_B0;
            end else if (r_state == LOAD) begin
                if (r_sel == COEF_A2) begin
                    r_sel <= COEF_B0;
                    if (!w_last) begin
                        r_sec <= r_sec + SW'(1);
                    end
                end else begin
                    r_sel <= r_sel + 3'd1;
                end
            end
            if (r_state == DONE) begin
                r_active <= r_target;
            end
        end
    end

    // The coefficient value is the bank entry at the registered pointers, so
    // a host write landing in the same cycle cannot alter what goes out.
    assign iir_coeff_wr_en   = (r_state == LOAD);
    assign iir_section_index = r_sec;
    assign iir_coeff_sel     = r_sel;
    assign iir_coeff_value   = (r_state == LOAD) ? w_rd_value : '0;

    assign switch_ack     = (r_state == DONE);
    assign switch_err     = r_err;
    assign busy           = (r_state != IDLE);
    assign active_profile = r_active;
    assign in_ready       = (r_state == IDLE);
    assign iir_din        = in_data;
    assign iir_din_valid  = in_valid && (r_state == IDLE);

endmodule

// File: tb/tb_iir_coef_sched.sv
// Randomized and directed bench for iir_coef_sched against a cycle-phase reference model.
module tb_iir_coef_sched;

    localparam int NS   = 2;
    localparam int NP   = 3;
    localparam int CW   = 16;
    localparam int DW   = 16;
    localparam int SW   = 1;
    localparam int PW   = 2;
    localparam int NWR  = 5 * NS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_wr_en = 1'b0;
    logic [PW-1:0] cfg_profile = '0;
    logic [SW-1:0] cfg_section = '0;
    logic [2:0]    cfg_sel = 3'd0;
    logic [CW-1:0] cfg_value = '0;
    logic          switch_req = 1'b0;
    logic [PW-1:0] switch_profile = '0;
    logic          switch_ack;
    logic          switch_err;
    logic          busy;
    logic [PW-1:0] active_profile;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] iir_din;
    logic          iir_din_valid;
    logic          iir_coeff_wr_en;
    logic [SW-1:0] iir_section_index;
    logic [2:0]    iir_coeff_sel;
    logic [CW-1:0] iir_coeff_value;

    iir_coef_sched #(
        .NUM_SECTIONS (NS),
        .COEF_WIDTH   (CW),
        .DATA_WIDTH   (DW),
        .NUM_PROFILES (NP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_profile       (cfg_profile),
        .cfg_section       (cfg_section),
        .cfg_sel           (cfg_sel),
        .cfg_value         (cfg_value),
        .switch_req        (switch_req),
        .switch_profile    (switch_profile),
        .switch_ack        (switch_ack),
        .switch_err        (switch_err),
        .busy              (busy),
        .active_profile    (active_profile),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .iir_din           (iir_din),
        .iir_din_valid     (iir_din_valid),
        .iir_coeff_wr_en   (iir_coeff_wr_en),
        .iir_section_index (iir_section_index),
        .iir_coeff_sel     (iir_coeff_sel),
        .iir_coeff_value   (iir_coeff_value)
    );

    always #5 clk = ~clk;

    // Reference model: phase -1 idle, 0 gate, 1..NWR writes, NWR+1 done.
    int          m_phase = -1;
    int          m_target = 0;
    int          m_active = 0;
    logic        m_err = 1'b0;
    logic [CW-1:0] m_bank [NP][NS][5];

    int n_vec = 0;
    int n_err = 0;

    int          low_cnt = 0;
    int          ack_cnt = 0;
    logic [CW-1:0] wr_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        int defs[5];
        defs = '{4096, 8192, 4096, 8192, 4096};
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < NS; s++)
                for (int c = 0; c < 5; c++)
                    m_bank[p][s][c] = CW'(defs[c]);
        m_phase  = -1;
        m_active = 0;
        m_err    = 1'b0;
    endtask

    // One clock: update the model from the sampled inputs, then check outputs mid-cycle.
    task automatic tick();
        int k;
        logic exp_wr;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_err = 1'b0;
            if (m_phase < 0) begin
                if (switch_req) begin
                    if (int'(switch_profile) < NP) begin
                        m_phase  = 0;
                        m_target = int'(switch_profile);
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (m_phase == NWR + 1) begin
                m_active = m_target;
                m_phase  = -1;
            end else begin
                m_phase++;
            end
            if (cfg_wr_en && cfg_sel <= 3'd4 && int'(cfg_profile) < NP && int'(cfg_section) < NS)
                m_bank[cfg_profile][cfg_section][cfg_sel] = cfg_value;
        end
        @(negedge clk);
        exp_wr = (m_phase >= 1) && (m_phase <= NWR);
        chk("in_ready", 32'(in_ready), 32'(m_phase < 0));
        chk("busy", 32'(busy), 32'(m_phase >= 0));
        chk("din_valid", 32'(iir_din_valid), 32'(in_valid && (m_phase < 0)));
        chk("din", 32'(iir_din), 32'(in_data));
        chk("ack", 32'(switch_ack), 32'(m_phase == NWR + 1));
        chk("err", 32'(switch_err), 32'(m_err));
        chk("active", 32'(active_profile), 32'(m_active));
        chk("wr_en", 32'(iir_coeff_wr_en), 32'(exp_wr));
        if (exp_wr) begin
            k = m_phase - 1;
            chk("wr_sec", 32'(iir_section_index), 32'(k / 5));
            chk("wr_sel", 32'(iir_coeff_sel), 32'(k % 5));
            chk("wr_value", 32'(iir_coeff_value), 32'(m_bank[m_target][k / 5][k % 5]));
        end
        if (!in_ready) low_cnt++;
        if (switch_ack) ack_cnt++;
        if (iir_coeff_wr_en) wr_q.push_back(iir_coeff_value);
    endtask

    task automatic clear_counts();
        low_cnt = 0;
        ack_cnt = 0;
        wr_q.delete();
    endtask

    task automatic run_to_idle();
        int guard;
        guard = 0;
        while (m_phase >= 0 && guard < 40) begin
            tick();
            guard++;
        end
        if (guard >= 40) chk("switch_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_switch(input int prof);
        switch_req     = 1'b1;
        switch_profile = PW'(prof);
        tick();
        switch_req = 1'b0;
        run_to_idle();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Open stream after reset.
        in_valid = 1'b1;
        in_data  = 16'd100;
        for (int i = 0; i < 5; i++) tick();

        // Load profile 2 with 1..10 and switch to it.
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < 5; c++) begin
                cfg_wr_en   = 1'b1;
                cfg_profile = 2'd2;
                cfg_section = SW'(s);
                cfg_sel     = 3'(c);
                cfg_value   = CW'(s * 5 + c + 1);
                tick();
            end
        end
        cfg_wr_en = 1'b0;
        clear_counts();
        do_switch(2);
        chk("ready_low_cycles", 32'(low_cnt), 32'd12);
        chk("ack_count", 32'(ack_cnt), 32'd1);
        chk("write_count", 32'(wr_q.size()), 32'd10);
        for (int i = 0; i < wr_q.size(); i++) chk("write_seq", 32'(wr_q[i]), 32'(i + 1));
        chk("active_after_load", 32'(active_profile), 32'd2);

        // Requests held through a load are ignored.
        clear_counts();
        switch_req     = 1'b1;
        switch_profile = 2'd1;
        tick();
        for (int g = 0; g < 40 && m_phase >= 0; g++) begin
            switch_req = (m_phase != NWR + 1);
            tick();
        end
        switch_req = 1'b0;
        chk("held_req_acks", 32'(ack_cnt), 32'd1);
        chk("held_req_writes", 32'(wr_q.size()), 32'd10);
        chk("held_req_active", 32'(active_profile), 32'd1);

        // Same-cycle write to the entry being driven sends the old value.
        clear_counts();
        switch_req     = 1'b1;
        switch_profile = 2'd2;
        tick();
        switch_req = 1'b0;
        for (int g = 0; g < 40 && m_phase >= 0; g++) begin
            cfg_wr_en   = (m_phase == 1);
            cfg_profile = 2'd2;
            cfg_section = '0;
            cfg_sel     = 3'd0;
            cfg_value   = 16'd777;
            tick();
        end
        cfg_wr_en = 1'b0;
        chk("same_cycle_old", 32'(wr_q.size() > 0 ? wr_q[0] : 16'hFFFF), 32'd1);
        clear_counts();
        do_switch(2);
        chk("reload_new", 32'(wr_q.size() > 0 ? wr_q[0] : 16'hFFFF), 32'd777);

        // Reset on the 4th LOAD cycle aborts the load.
        clear_counts();
        switch_req     = 1'b1;
        switch_profile = 2'd1;
        tick();
        switch_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_wr_en", 32'(iir_coeff_wr_en), 32'd0);
        chk("abort_active", 32'(active_profile), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("abort_no_ack", 32'(ack_cnt), 32'd0);
        chk("abort_writes", 32'(wr_q.size()), 32'd4);

        // Out-of-range profile is rejected.
        clear_counts();
        switch_req     = 1'b1;
        switch_profile = 2'd3;
        tick();
        switch_req = 1'b0;
        chk("err_pulse", 32'(switch_err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        tick();
        chk("err_clear", 32'(switch_err), 32'd0);
        chk("err_no_writes", 32'(wr_q.size()), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            cfg_wr_en   = ($urandom_range(0, 2) == 0);
            cfg_profile = PW'($urandom_range(0, 3));
            cfg_section = SW'($urandom_range(0, 1));
            cfg_sel     = 3'($urandom_range(0, 7));
            cfg_value   = CW'($urandom);
            switch_req  = ($urandom_range(0, 7) == 0);
            if (m_phase < 0) switch_profile = PW'($urandom_range(0, 3));
            in_valid    = $urandom_range(0, 1) == 1;
            in_data     = DW'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
